// File: rtl/dev_debug_pkg.sv
// Shared constants for the dev_debug_input family: register offsets, CTRL bit positions
// and the read value returned for unmapped addresses.
// Latency: n/a (constants only). Backpressure: n/a.
package dev_debug_pkg;

   localparam logic [7:0]  ADDR_DATA     = 8'h00;
   localparam logic [7:0]  ADDR_CTRL     = 8'h04;
   localparam logic [7:0]  ADDR_COUNT    = 8'h08;
   localparam logic [7:0]  ADDR_VAL_BASE = 8'h10;

   localparam int          CTRL_POP      = 0;
   localparam int          CTRL_FLUSH    = 1;
   localparam int          CTRL_CLR_OVF  = 2;
   localparam int          CTRL_IRQ_EN   = 3;

   localparam logic [31:0] UNMAPPED_DAT  = 32'hdead_beef;

endpackage

// File: rtl/debug_sync_fifo.sv
// Synchronous word FIFO with flush; head word is shown combinationally from storage.
// Latency: 1 cycle push-to-head; pop advances the head at the next edge.
// Backpressure: none; a push while full without a concurrent pop is dropped (caller flags it).
// Ports: clk/rst, i_push/i_push_dat, i_pop, i_flush (highest priority),
//        o_head_dat, o_count (0..DEPTH), o_full, o_empty.
module debug_sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_push_dat,
   input  logic                     i_pop,
   input  logic                     i_flush,
   output logic [WIDTH-1:0]         o_head_dat,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_full,
   output logic                     o_empty
);

   localparam int           AW       = $clog2(DEPTH);
   localparam logic [AW:0]  FULL_CNT = DEPTH[AW:0];

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_rd_ptr;
   logic [AW-1:0]    r_wr_ptr;
   logic [AW:0]      r_count;

   logic w_empty;
   logic w_full;
   logic w_do_pop;
   logic w_do_push;

   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == FULL_CNT);
   assign w_do_pop  = i_pop & ~w_empty & ~i_flush;
   // When full, a concurrent pop frees the slot the write pointer already points at.
   assign w_do_push = i_push & (~w_full | w_do_pop) & ~i_flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_rd_ptr <= '0;
         r_wr_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage carries no reset; only the pointers define which words are valid.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_push_dat;
   end

   assign o_head_dat = r_mem[r_rd_ptr];
   assign o_count    = r_count;
   assign o_full     = w_full;
   assign o_empty    = w_empty;

endmodule

// File: rtl/dev_debug_input_fifo.sv
// Memory-mapped debug input: N_VAL CPU value registers plus a DEPTH-word stimulus FIFO.
// Latency: reads combinational; writes, pushes and pops take effect at the next posedge.
// Backpressure: none; tb_full is advisory, pushes while full are dropped and set sticky ovf.
// Ports: clk/rst; dev_addr/dev_in/we/dev_out CPU bus; irq = irq_en & ~empty;
//        tb_push/tb_data/tb_full testbench feed.
module dev_debug_input_fifo
   import dev_debug_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int N_VAL = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic [31:0] dev_out,
   input  logic [31:0] dev_in,
   input  logic [7:0]  dev_addr,
   input  logic        we,
   output logic        irq,
   input  logic        tb_push,
   input  logic [31:0] tb_data,
   output logic        tb_full
);

   localparam int CW = $clog2(DEPTH) + 1;

   logic [31:0]   r_val [N_VAL];
   logic          r_irq_en;
   logic          r_ovf;

   logic          w_ctrl_wr;
   logic          w_pop;
   logic          w_flush;
   logic          w_clr_ovf;
   logic          w_ovf_set;
   logic [31:0]   w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_val_off;
   logic [3:0]    w_val_idx;
   logic          w_val_hit;

   assign w_ctrl_wr = we && (dev_addr == ADDR_CTRL);
   assign w_pop     = w_ctrl_wr & dev_in[CTRL_POP];
   assign w_flush   = w_ctrl_wr & dev_in[CTRL_FLUSH];
   assign w_clr_ovf = w_ctrl_wr & dev_in[CTRL_CLR_OVF];

   // A pop while full always succeeds (full implies non-empty), so it rescues the push.
   assign w_ovf_set = tb_push & w_full & ~w_pop & ~w_flush;

   // VAL window: word-aligned, and only the first N_VAL words are mapped.
   assign w_val_off = dev_addr - ADDR_VAL_BASE;
   assign w_val_idx = w_val_off[5:2];
   assign w_val_hit = (dev_addr >= ADDR_VAL_BASE) && (w_val_off[1:0] == 2'b00) &&
                      (w_val_off[7:6] == 2'b00) && ({1'b0, w_val_idx} < 5'(N_VAL));

   debug_sync_fifo #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (tb_push),
      .i_push_dat (tb_data),
      .i_pop      (w_pop),
      .i_flush    (w_flush),
      .o_head_dat (w_head),
      .o_count    (w_count),
      .o_full     (w_full),
      .o_empty    (w_empty)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_irq_en <= 1'b0;
         r_ovf    <= 1'b0;
      end else begin
         if (w_ctrl_wr) r_irq_en <= dev_in[CTRL_IRQ_EN];
         // Set has priority over a same-cycle clear.
         if (w_ovf_set)      r_ovf <= 1'b1;
         else if (w_clr_ovf) r_ovf <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < N_VAL; i++) r_val[i] <= '0;
      end else if (we && w_val_hit) begin
         for (int i = 0; i < N_VAL; i++) begin
            if (w_val_idx == 4'(i)) r_val[i] <= dev_in;
         end
      end
   end

   always_comb begin
      dev_out = UNMAPPED_DAT;
      if (dev_addr == ADDR_DATA) begin
         if (!w_empty) dev_out = w_head;
      end else if (dev_addr == ADDR_CTRL) begin
         dev_out = {16'h0000, {(8 - CW){1'b0}}, w_count, 4'b0000,
                    r_irq_en, r_ovf, w_full, w_empty};
      end else if (dev_addr == ADDR_COUNT) begin
         dev_out = {{(32 - CW){1'b0}}, w_count};
      end else if (w_val_hit) begin
         for (int i = 0; i < N_VAL; i++) begin
            if (w_val_idx == 4'(i)) dev_out = r_val[i];
         end
      end
   end

   assign irq     = r_irq_en & ~w_empty;
   assign tb_full = w_full;

endmodule

// File: tb/tb_dev_debug_input_fifo.sv
// Self-checking bench for dev_debug_input_fifo: queue-based model compared every cycle,
// plus directed literal expectations.
// Latency/backpressure: inputs driven 2 time units after posedge, outputs sampled before negedge.
module tb_dev_debug_input_fifo;

   localparam int DEPTH = 8;
   localparam int N_VAL = 4;
   localparam logic [31:0] DB = 32'hdead_beef;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] dev_out;
   logic [31:0] dev_in = '0;
   logic [7:0]  dev_addr = '0;
   logic        we = 1'b0;
   logic        irq;
   logic        tb_push = 1'b0;
   logic [31:0] tb_data = '0;
   logic        tb_full;

   int n_checks = 0;
   int n_errors = 0;
   bit run_cmp  = 1'b0;

   // Model state
   logic [31:0] q[$];
   bit          m_ovf;
   bit          m_irq_en;
   logic [31:0] m_val [N_VAL];

   dev_debug_input_fifo #(.DEPTH(DEPTH), .N_VAL(N_VAL)) dut (
      .clk      (clk),
      .rst      (rst),
      .dev_out  (dev_out),
      .dev_in   (dev_in),
      .dev_addr (dev_addr),
      .we       (we),
      .irq      (irq),
      .tb_push  (tb_push),
      .tb_data  (tb_data),
      .tb_full  (tb_full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] exp_read(input logic [7:0] a);
      int n;
      n = q.size();
      if (a == 8'h00) return (n > 0) ? q[0] : DB;
      if (a == 8'h04) return (n << 8) | (m_irq_en << 3) | (m_ovf << 2) |
                             ((n == DEPTH) << 1) | (n == 0);
      if (a == 8'h08) return n;
      if (a >= 8'h10 && a < 8'h10 + 4 * N_VAL && a[1:0] == 2'b00) return m_val[(a - 8'h10) >> 2];
      return DB;
   endfunction

   // Model: applies the register-level rules directly to a queue.
   always @(posedge clk or posedge rst) begin
      bit ctrl_wr, pop, flush, clr, set;
      if (rst) begin
         q.delete();
         m_ovf    = 1'b0;
         m_irq_en = 1'b0;
         for (int i = 0; i < N_VAL; i++) m_val[i] = '0;
      end else begin
         ctrl_wr = we && dev_addr == 8'h04;
         pop     = ctrl_wr && dev_in[0];
         flush   = ctrl_wr && dev_in[1];
         clr     = ctrl_wr && dev_in[2];
         set     = 1'b0;
         if (ctrl_wr) m_irq_en = dev_in[3];
         if (flush) begin
            q.delete();
         end else begin
            if (tb_push && q.size() == DEPTH && !(pop && q.size() > 0)) begin
               set = 1'b1;
            end else begin
               if (pop && q.size() > 0) void'(q.pop_front());
               if (tb_push) q.push_back(tb_data);
            end
         end
         if (set) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (we && dev_addr >= 8'h10 && dev_addr < 8'h10 + 4 * N_VAL && dev_addr[1:0] == 2'b00)
            m_val[(dev_addr - 8'h10) >> 2] = dev_in;
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      if (run_cmp && !rst) begin
         chk("cyc_dout", dev_out, exp_read(dev_addr));
         chk("cyc_irq",  {31'b0, irq},     {31'b0, (m_irq_en && q.size() != 0)});
         chk("cyc_full", {31'b0, tb_full}, {31'b0, (q.size() == DEPTH)});
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input logic [31:0] d);
      tb_push = 1'b1;
      tb_data = d;
      tick();
      tb_push = 1'b0;
   endtask

   task automatic wr(input logic [7:0] a, input logic [31:0] d);
      we       = 1'b1;
      dev_addr = a;
      dev_in   = d;
      tick();
      we       = 1'b0;
   endtask

   task automatic rd_chk(input string name, input logic [7:0] a, input logic [31:0] exp);
      dev_addr = a;
      #1;
      chk(name, dev_out, exp);
   endtask

   initial begin
      #12 rst = 1'b0;
      run_cmp = 1'b1;
      tick();

      // Reset state
      rd_chk("rst_data",  8'h00, DB);
      rd_chk("rst_ctrl",  8'h04, 32'h1);
      rd_chk("rst_count", 8'h08, 32'h0);
      rd_chk("rst_val0",  8'h10, 32'h0);
      rd_chk("rst_3c",    8'h3c, DB);
      chk("rst_irq",  {31'b0, irq},     32'h0);
      chk("rst_full", {31'b0, tb_full}, 32'h0);

      // Basic push / pop
      push(32'h11); push(32'h22); push(32'h33);
      rd_chk("cnt3",  8'h08, 32'd3);
      rd_chk("head11", 8'h00, 32'h11);
      wr(8'h04, 32'h1);
      rd_chk("head22", 8'h00, 32'h22);
      rd_chk("cnt2",   8'h08, 32'd2);
      wr(8'h04, 32'h1);
      wr(8'h04, 32'h1);
      rd_chk("empty_data", 8'h00, DB);
      rd_chk("empty_ctrl", 8'h04, 32'h1);
      wr(8'h04, 32'h1);                      // pop while empty: ignored
      rd_chk("pop_empty_cnt", 8'h08, 32'd0);

      // Fill, overflow, clear, push+pop while full
      for (int i = 0; i < 8; i++) begin
         if (i == 7) chk("full7", {31'b0, tb_full}, 32'h0);
         push(32'h100 + i);
      end
      chk("full8", {31'b0, tb_full}, 32'h1);
      push(32'h1FF);
      rd_chk("ovf_ctrl", 8'h04, 32'h806);
      rd_chk("ovf_cnt",  8'h08, 32'd8);
      wr(8'h04, 32'h4);
      rd_chk("clr_ovf_ctrl", 8'h04, 32'h802);
      tb_push = 1'b1; tb_data = 32'hBEE;
      we = 1'b1; dev_addr = 8'h04; dev_in = 32'h1;
      tick();
      tb_push = 1'b0; we = 1'b0;
      rd_chk("pp_cnt",  8'h08, 32'd8);
      rd_chk("pp_ovf",  8'h04, 32'h802);
      for (int i = 1; i < 8; i++) begin
         rd_chk("drain", 8'h00, 32'h100 + i);
         wr(8'h04, 32'h1);
      end
      rd_chk("tail_bee", 8'h00, 32'hBEE);
      wr(8'h04, 32'h1);
      rd_chk("drained", 8'h08, 32'd0);

      // Wrap-around, 1-in/1-out
      for (int i = 0; i < 20; i++) begin
         push(32'h5000 + i);
         rd_chk("wrap_cnt",  8'h08, 32'd1);
         rd_chk("wrap_data", 8'h00, 32'h5000 + i);
         wr(8'h04, 32'h1);
      end
      rd_chk("wrap_end", 8'h08, 32'd0);

      // Interrupt and flush
      wr(8'h04, 32'h8);
      chk("irq_idle", {31'b0, irq}, 32'h0);
      push(32'hAB);
      chk("irq_on", {31'b0, irq}, 32'h1);
      tb_push = 1'b1; tb_data = 32'hCD;
      we = 1'b1; dev_addr = 8'h04; dev_in = 32'hA;
      tick();
      tb_push = 1'b0; we = 1'b0;
      chk("irq_flush", {31'b0, irq}, 32'h0);
      rd_chk("flush_ctrl", 8'h04, 32'h9);
      for (int i = 0; i < 8; i++) push(32'h700 + i);
      tb_push = 1'b1; tb_data = 32'hEE;
      we = 1'b1; dev_addr = 8'h04; dev_in = 32'hA;
      tick();
      tb_push = 1'b0; we = 1'b0;
      rd_chk("flush_full_ctrl", 8'h04, 32'h9);

      // VAL bank, unmapped writes, async reset
      wr(8'h14, 32'hCAFE);
      rd_chk("val1", 8'h14, 32'hCAFE);
      wr(8'h15, 32'h1234);
      wr(8'h20, 32'h5678);
      rd_chk("unal_rd",  8'h15, DB);
      rd_chk("val4_rd",  8'h20, DB);
      rd_chk("val1_kept", 8'h14, 32'hCAFE);
      rd_chk("val3", 8'h1c, 32'h0);
      push(32'h99);
      tb_push = 1'b1; tb_data = 32'h77;
      rst = 1'b1;
      #1;
      rd_chk("arst_val1", 8'h14, 32'h0);
      rd_chk("arst_cnt",  8'h08, 32'd0);
      @(posedge clk);
      #3;
      rst = 1'b0;
      tb_push = 1'b0;
      rd_chk("rel_cnt", 8'h08, 32'd0);
      tick();
      rd_chk("rel_data", 8'h00, DB);

      run_cmp = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/dev_debug_input_fifo.md
# dev_debug_input_fifo

Parametrised memory-mapped debug input device on the same device bus as the other `dev_*` peripherals. It combines a bank of `N_VAL` CPU-readable value registers with a `DEPTH`-entry word FIFO that the testbench pushes into and the CPU drains. It provides a sticky overflow flag and a level interrupt, so test programs can consume a stream of stimulus words instead of a single fixed value.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, 2..64.
- `N_VAL`, 4: value registers; 1..16.

Ports:
- `clk`  in  1  posedge clock
- `rst`  in  1  reset, asynchronous, active-high
- `dev_out`  out  32  read data for `dev_addr`; combinational
- `dev_in`  in  32  write data
- `dev_addr`  in  8  byte address within the device
- `we`  in  1  write strobe, sampled on posedge `clk`
- `irq`  out  1  level interrupt
- `tb_push`  in  1  testbench push strobe, sampled on posedge `clk`
- `tb_data`  in  32  word to push
- `tb_full`  out  1  FIFO full; combinational from state

## Operation
Register map. Addresses are exact byte addresses; any other address, including unaligned ones, reads `32'hdead_beef`, and writes to it are ignored.
- `0x00` DATA (R): FIFO head word, or `32'hdead_beef` when empty. A read never pops, because the bus has no read strobe.
- `0x04` CTRL/STATUS
  - Write: bit0 POP, bit1 FLUSH, bit2 CLR_OVF (write 1 to clear), bit3 IRQ_EN (stored value).
  - Read: bit0 empty, bit1 full, bit2 ovf, bit3 irq_en, bits[15:8] count, other bits 0.
- `0x08` COUNT (R): zero-extended entry count, 0..`DEPTH`.
- `0x10 + 4*i`, i < `N_VAL`: VAL[i], read/write. Addresses for i ≥ `N_VAL` fall under the unmapped rule. The testbench may also force VAL[i] hierarchically.

FIFO rules per clock edge, in priority order:
- FLUSH: count, read pointer and write pointer go to 0. Any same-cycle push and pop are discarded, and ovf is not set.
- Push with pop (POP written while count > 0): both take effect and count is unchanged.
- Push while full and no pop: word dropped, ovf set to 1.
- POP while empty: ignored.
- CLR_OVF in the same cycle as an overflowing push: set wins, ovf = 1.
- Pointers are `$clog2(DEPTH)` bits and wrap modulo `DEPTH`. Count is `$clog2(DEPTH)+1` bits.

Interrupt: `irq` = irq_en & ~empty, derived combinationally from registered state.

Reset values: all VAL = 0, count/pointers = 0, ovf = 0, irq_en = 0. At reset `dev_out` for addr 0x00 = `32'hdead_beef`, `irq` = 0, `tb_full` = 0. FIFO storage is not reset.

## Timing
- All state updates on posedge `clk`. `rst` clears state immediately, regardless of `clk`.
- Push latency 1: a word pushed at edge N is visible on DATA and counted from edge N onward, i.e. in the cycle following the push.
- POP at edge N: the next word appears on DATA after edge N.
- `irq` rises the cycle after the first push into an empty FIFO (when enabled) and falls the cycle after the last POP.
- `tb_full` reflects count == `DEPTH` in the same cycle. The testbench may still push while full; the word is dropped and ovf is set.
- Reset mid-stream: FIFO contents are lost and any push on the reset-release edge is ignored.

## Structure
- Package `dev_debug_pkg`: register offsets (DATA, CTRL, COUNT, VAL_BASE), CTRL bit indices, and the `32'hdead_beef` unmapped constant. Shared with `dev_debug_input` successors and the testbench.
- Sub-module `debug_sync_fifo` (params `WIDTH`, `DEPTH`): storage, pointers, count, push/pop/flush, full/empty. Overflow and interrupt logic stay in the top level.
- Top level: address decode, read mux, VAL bank, CTRL register.

## Test plan
- Reset, then read 0x00, 0x04, 0x08, 0x10 and 0x3c → `dead_beef`, `0x1`, `0`, `0`, `dead_beef` (`N_VAL`=4).
- Push 0x11, 0x22, 0x33 → COUNT=3, DATA=0x11; write POP → DATA=0x22, COUNT=2; POP twice more → DATA=`dead_beef`, empty=1.
- Push 9 words with `DEPTH`=8 → `tb_full`=1 after the 8th; the 9th is dropped, ovf=1, COUNT=8; CLR_OVF → ovf=0. Push and POP in the same cycle while full → COUNT stays 8, new word lands at the tail.
- Wrap: push/pop 20 words in a 1-in/1-out pattern → every word is read back in order and COUNT never exceeds 1.
- IRQ_EN=1, push 0xAB → `irq`=1 one cycle later; FLUSH concurrent with a push → COUNT=0, `irq`=0, ovf=0.
- Write 0xCAFE to 0x14 → VAL[1] reads 0xCAFE; assert `rst` between clock edges → VAL[1]=0 and COUNT=0 immediately.
